// File: rtl/bp_run_if.sv
// Debug-path bundle between the CPU/board side and the run/halt controller.
interface bp_run_if #(
  parameter int unsigned CNT_W = 8
) ();

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned CAUSE_W = 2;

  logic [ADDR_W-1:0]  cpu_addr;
  logic               instr_start;
  logic [ADDR_W-1:0]  bp_addr;
  logic               bp_enable;
  logic               btn_halt;
  logic               btn_step;
  logic               btn_cont;
  logic               cpu_run;
  logic               halted;
  logic [CAUSE_W-1:0] break_cause;
  logic [CNT_W-1:0]   hit_count;

  modport master (
    output cpu_addr, instr_start, bp_addr, bp_enable,
    output btn_halt, btn_step, btn_cont,
    input  cpu_run, halted, break_cause, hit_count
  );

  modport slave (
    input  cpu_addr, instr_start, bp_addr, bp_enable,
    input  btn_halt, btn_step, btn_cont,
    output cpu_run, halted, break_cause, hit_count
  );

endinterface

// File: rtl/bp_run_ctrl.sv
// Run/halt controller: breakpoint compare at instruction boundaries, CPU clock-enable,
// button-driven continue/step/halt sequencing, halt cause and saturating hit counter.
module bp_run_ctrl #(
  parameter bit          START_HALTED = 1'b0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic     clock,
  input  logic     reset,
  bp_run_if.slave  bus
);

  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned BTN_W   = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_BP     = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_MANUAL = 2'b10;
  localparam logic [CAUSE_W-1:0] CAUSE_STEP   = 2'b11;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT_REQ,
    S_STEP,
    S_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic               skip_q, skip_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic [BTN_W-1:0]   btn_prev_q;

  logic [BTN_W-1:0]   btn_lvl;
  logic [BTN_W-1:0]   btn_press;
  logic               press_halt, press_step, press_cont;
  logic               cand;
  logic               boundary;
  logic               match;
  logic               cpu_run_c;

  // Rising-edge press detection; prev bits come out of reset high so a held button is ignored.
  assign btn_lvl    = {bus.btn_halt, bus.btn_step, bus.btn_cont};
  assign btn_press  = btn_lvl & ~btn_prev_q;
  assign press_halt = btn_press[2];
  assign press_step = btn_press[1];
  assign press_cont = btn_press[0];

  // cand is an instruction boundary the CPU would take if allowed to run; skip masks the parked one.
  assign cand     = bus.instr_start & (state_q != S_HALTED);
  assign boundary = cand & ~skip_q;
  assign match    = boundary & bus.bp_enable & (bus.cpu_addr == bus.bp_addr);

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    cause_d   = cause_q;
    hits_d    = hits_q;
    cpu_run_c = 1'b0;

    // While skip is set no boundary can halt, so cand here is an accepted fetch.
    if (skip_q && cand) begin
      skip_d = 1'b0;
    end

    unique case (state_q)
      S_RUN: begin
        cpu_run_c = ~match;
        if (press_halt) begin
          state_d = S_HALT_REQ;
        end
      end
      S_HALT_REQ: begin
        cpu_run_c = ~boundary;
        if (boundary) begin
          state_d = S_HALTED;
          cause_d = CAUSE_MANUAL;
        end
      end
      S_STEP: begin
        cpu_run_c = ~boundary;
        if (boundary) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STEP;
        end
      end
      S_HALTED: begin
        cpu_run_c = 1'b0;
        if (press_step) begin
          state_d = S_STEP;
          skip_d  = (cause_q != CAUSE_NONE);
        end else if (press_cont) begin
          state_d = S_RUN;
          skip_d  = (cause_q != CAUSE_NONE);
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    // A breakpoint hit overrides whatever the active state decided.
    if (match) begin
      state_d = S_HALTED;
      cause_d = CAUSE_BP;
      if (hits_q != {CNT_W{1'b1}}) begin
        hits_d = hits_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= START_HALTED ? S_HALTED : S_RUN;
      skip_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
      hits_q     <= '0;
      btn_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      cause_q    <= cause_d;
      hits_q     <= hits_d;
      btn_prev_q <= btn_lvl;
    end
  end

  assign bus.cpu_run     = cpu_run_c;
  assign bus.halted      = (state_q == S_HALTED);
  assign bus.break_cause = cause_q;
  assign bus.hit_count   = hits_q;

endmodule

// File: tb/tb_bp_run_ctrl.sv
// Bench for bp_run_ctrl: a looping CPU stub and a cause/pending-request reference model.
module tb_bp_run_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned MAXH  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  logic reset1;

  always #5 clock = ~clock;

  bp_run_if #(.CNT_W(CNT_W)) bus0 ();
  bp_run_if #(.CNT_W(CNT_W)) bus1 ();

  bp_run_ctrl #(.START_HALTED(1'b0), .CNT_W(CNT_W)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  bp_run_ctrl #(.START_HALTED(1'b1), .CNT_W(CNT_W)) u_dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: halted flag, pending halt request (0 none, 2 manual, 3 step), parked skip.
  bit          m_halted = 1'b0;
  int          m_pend   = 0;
  bit          m_skip   = 1'b0;
  int          m_cause  = 0;
  int unsigned m_hits   = 0;
  bit [2:0]    m_prev   = 3'b111;
  bit          m_boundary, m_hit, m_run;

  // CPU stub: program loops 0x0100..0x0156 by 2, each instruction 1..3 cycles.
  logic [15:0] pc  = 16'h0100;
  int          len = 2;
  int          idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] next_pc(input logic [15:0] a);
    return (a == 16'h0156) ? 16'h0100 : a + 16'd2;
  endfunction

  task automatic drive_cpu();
    bus0.instr_start = (idx == 0);
    bus0.cpu_addr    = (idx == 0) ? pc : 16'($urandom);
  endtask

  task automatic model_comb();
    m_boundary = !m_halted && bus0.instr_start && !m_skip;
    m_hit      = m_boundary && bus0.bp_enable && (bus0.cpu_addr == bus0.bp_addr);
    m_run      = !m_halted && !m_hit && !(m_boundary && m_pend != 0);
  endtask

  task automatic model_seq();
    bit p_halt, p_step, p_cont;
    if (reset) begin
      m_halted = 1'b0;
      m_pend   = 0;
      m_skip   = 1'b0;
      m_cause  = 0;
      m_hits   = 0;
      m_prev   = 3'b111;
    end else begin
      p_halt = bus0.btn_halt && !m_prev[2];
      p_step = bus0.btn_step && !m_prev[1];
      p_cont = bus0.btn_cont && !m_prev[0];
      m_prev = {bus0.btn_halt, bus0.btn_step, bus0.btn_cont};
      if (!m_halted) begin
        if (bus0.instr_start && m_skip) m_skip = 1'b0;
        if (m_hit) begin
          m_halted = 1'b1;
          m_cause  = 1;
          m_pend   = 0;
          if (m_hits < MAXH) m_hits++;
        end else if (m_boundary && m_pend != 0) begin
          m_halted = 1'b1;
          m_cause  = m_pend;
          m_pend   = 0;
        end else if (m_pend == 0 && p_halt) begin
          m_pend = 2;
        end
      end else if (p_step) begin
        m_halted = 1'b0;
        m_pend   = 3;
        m_skip   = (m_cause != 0);
      end else if (p_cont) begin
        m_halted = 1'b0;
        m_pend   = 0;
        m_skip   = (m_cause != 0);
      end
    end
  endtask

  task automatic cpu_advance();
    if (m_run) begin
      if (idx == len - 1) begin
        pc  = next_pc(pc);
        len = int'($urandom_range(1, 3));
        idx = 0;
      end else begin
        idx++;
      end
    end
  endtask

  // One clock: check outputs mid-cycle, then advance model and CPU on the edge.
  task automatic cycle();
    @(negedge clock);
    model_comb();
    chk("cpu_run",     32'(bus0.cpu_run),     32'(m_run));
    chk("halted",      32'(bus0.halted),      32'(m_halted));
    chk("break_cause", 32'(bus0.break_cause), 32'(m_cause));
    chk("hit_count",   32'(bus0.hit_count),   32'(m_hits));
    @(posedge clock);
    model_seq();
    cpu_advance();
    #1;
    drive_cpu();
  endtask

  task automatic press(input bit [2:0] which);
    bus0.btn_halt = which[2];
    bus0.btn_step = which[1];
    bus0.btn_cont = which[0];
    cycle();
    bus0.btn_halt = 1'b0;
    bus0.btn_step = 1'b0;
    bus0.btn_cont = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int max_cyc);
    int n = 0;
    while (!m_halted && n < max_cyc) begin
      cycle();
      n++;
    end
    if (!m_halted) chk({tag, "_timeout"}, 32'(m_halted), 32'd1);
  endtask

  initial begin
    reset  = 1'b1;
    reset1 = 1'b1;
    bus0.bp_addr   = 16'h0150;
    bus0.bp_enable = 1'b1;
    bus0.btn_halt  = 1'b0;
    bus0.btn_step  = 1'b0;
    bus0.btn_cont  = 1'b0;
    drive_cpu();
    bus1.cpu_addr    = 16'h0200;
    bus1.instr_start = 1'b0;
    bus1.bp_addr     = 16'h0300;
    bus1.bp_enable   = 1'b1;
    bus1.btn_halt    = 1'b0;
    bus1.btn_step    = 1'b0;
    bus1.btn_cont    = 1'b1;

    // START_HALTED instance: continue held through reset, then a step from reset.
    repeat (2) @(posedge clock);
    #1 reset1 = 1'b0;
    @(negedge clock);
    chk("sh_rst_halted", 32'(bus1.halted),      32'd1);
    chk("sh_rst_run",    32'(bus1.cpu_run),     32'd0);
    chk("sh_rst_cause",  32'(bus1.break_cause), 32'd0);
    chk("sh_rst_hits",   32'(bus1.hit_count),   32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sh_held_cont",  32'(bus1.halted),      32'd1);
    bus1.btn_cont = 1'b0;
    bus1.btn_step = 1'b1;
    @(posedge clock);
    #1 bus1.btn_step = 1'b0;
    @(negedge clock);
    chk("sh_step_run",    32'(bus1.cpu_run), 32'd1);
    chk("sh_step_halted", 32'(bus1.halted),  32'd0);
    bus1.instr_start = 1'b1;
    @(negedge clock);
    chk("sh_step_freeze", 32'(bus1.cpu_run), 32'd0);
    @(posedge clock);
    #1;
    chk("sh_step_done",   32'(bus1.halted),      32'd1);
    chk("sh_step_cause",  32'(bus1.break_cause), 32'd3);
    chk("sh_step_hits",   32'(bus1.hit_count),   32'd0);

    // Main instance out of reset.
    @(posedge clock);
    model_seq();
    #1 reset = 1'b0;
    chk("rst_halted", 32'(bus0.halted),      32'd0);
    chk("rst_cause",  32'(bus0.break_cause), 32'd0);
    chk("rst_hits",   32'(bus0.hit_count),   32'd0);

    // Breakpoint at 0x0150.
    run_until_halt("bp1", 500);
    chk("bp1_halted", 32'(bus0.halted),      32'd1);
    chk("bp1_cause",  32'(bus0.break_cause), 32'd1);
    chk("bp1_hits",   32'(bus0.hit_count),   32'd1);
    chk("bp1_addr",   32'(pc),               32'h0150);
    chk("bp1_frozen", 32'(bus0.cpu_run),     32'd0);

    // Continue from the parked breakpoint: no re-trigger, hits again on the next loop.
    press(3'b001);
    chk("cont_run", 32'(bus0.cpu_run), 32'd1);
    run_until_halt("bp2", 500);
    chk("bp2_hits",  32'(bus0.hit_count),   32'd2);
    chk("bp2_cause", 32'(bus0.break_cause), 32'd1);
    chk("bp2_addr",  32'(pc),               32'h0150);

    // Single step from the breakpoint.
    press(3'b010);
    run_until_halt("step1", 50);
    chk("step1_cause", 32'(bus0.break_cause), 32'd3);
    chk("step1_hits",  32'(bus0.hit_count),   32'd2);
    chk("step1_addr",  32'(pc),               32'h0152);

    // Manual halt mid-instruction with compare disabled.
    bus0.bp_enable = 1'b0;
    press(3'b001);
    for (int i = 0; i < 20 && !(idx != 0 && m_pend == 0); i++) cycle();
    press(3'b100);
    run_until_halt("manual", 50);
    chk("manual_cause", 32'(bus0.break_cause), 32'd2);

    // Step and continue together: step wins.
    press(3'b011);
    run_until_halt("step_wins", 50);
    chk("step_wins_cause", 32'(bus0.break_cause), 32'd3);

    // Halt button held through reset gives no press.
    bus0.btn_halt = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (6) cycle();
    chk("held_halt_running", 32'(bus0.halted),  32'd0);
    chk("held_halt_run",     32'(bus0.cpu_run | bus0.instr_start ^ 1'b1), 32'd1);
    bus0.btn_halt = 1'b0;
    cycle();

    // Counter saturation.
    bus0.bp_enable = 1'b1;
    bus0.bp_addr   = 16'h0120;
    for (int i = 0; i < 300; i++) begin
      press(3'b001);
      run_until_halt("sat", 600);
    end
    chk("sat_hits", 32'(bus0.hit_count), 32'(MAXH));

    // Reset while stepping.
    press(3'b010);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("stp_rst_halted", 32'(bus0.halted),      32'd0);
    chk("stp_rst_cause",  32'(bus0.break_cause), 32'd0);
    chk("stp_rst_hits",   32'(bus0.hit_count),   32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bus0.btn_halt = ($urandom_range(0, 11) == 0);
      bus0.btn_step = ($urandom_range(0, 9) == 0);
      bus0.btn_cont = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 40) == 0) bus0.bp_enable = ~bus0.bp_enable;
      if ($urandom_range(0, 60) == 0) bus0.bp_addr = 16'h0100 + 16'(2 * $urandom_range(0, 43));
      reset = ($urandom_range(0, 700) == 0);
      cycle();
    end
    reset = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_run_ctrl.md
Name: bp_run_ctrl

Overview:
- Run/halt controller for the CPU debug path.
- Compares the CPU fetch address against the 16-bit breakpoint address at each instruction boundary.
- Freezes the CPU through a clock-enable when the addresses match.
- Sequences continue, single-step and manual-halt requests from debounced board buttons, and reports halt status and cause to the display logic.

Parameters:
- START_HALTED, 0, 1 = state after reset is HALTED instead of RUN.
- CNT_W, 8, width of the saturating breakpoint hit counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clock.
- cpu_addr  input  16  CPU PC / fetch address; valid when instr_start=1.
- instr_start  input  1  high in the first cycle of an instruction fetch; stays high while the CPU is frozen in that cycle.
- bp_addr  input  16  breakpoint address from the breakpoint register block.
- bp_enable  input  1  breakpoint compare enable.
- btn_halt  input  1  debounced level, synchronous to clock.
- btn_step  input  1  debounced level.
- btn_cont  input  1  debounced level.
- cpu_run  output  1  CPU clock-enable; CPU advances only in cycles where cpu_run=1.
- halted  output  1  state==HALTED.
- break_cause  output  2  00 none/reset, 01 breakpoint, 10 manual halt, 11 step done.
- hit_count  output  CNT_W  saturating count of breakpoint halts.

Behaviour:
- Button edge detection:
  - Each btn_* has a prev register; a press = level 1 & prev 0.
  - prev registers reset to 1, so a button held through reset gives no press.
- Definitions (combinational):
  - accept = cpu_run & instr_start.
  - match = accept & bp_enable & (cpu_addr==bp_addr) & !skip.
  - boundary = accept & !skip.
- States: RUN, HALT_REQ, STEP, HALTED.
- cpu_run (combinational):
  - RUN: 1 unless match.
  - HALT_REQ and STEP: 1 unless boundary or match.
  - HALTED: 0.
  - Consequence: a halting boundary cycle is never executed; the CPU freezes in that cycle with instr_start still high.
- RUN:
  - match → HALTED, cause=01, hit_count+1 (saturate at all-ones).
  - Otherwise, halt press → HALT_REQ.
  - Step and continue presses ignored.
- HALT_REQ:
  - match → HALTED, cause=01, hit_count+1.
  - Otherwise, boundary → HALTED, cause=10.
  - All presses ignored.
- STEP:
  - match → HALTED, cause=01, hit_count+1.
  - Otherwise, boundary → HALTED, cause=11.
  - Presses ignored.
- HALTED:
  - Step press → STEP.
  - Otherwise, continue press → RUN.
  - Halt press ignored.
  - Step wins over a simultaneous continue.
- Skip flag:
  - Set on leaving HALTED only if cause≠00, i.e. the CPU is parked at a boundary.
  - Cleared on the first accept cycle after it is set.
  - While set, match and boundary are suppressed.
  - Effect: continue/step never re-trigger on the parked instruction. A step from a boundary executes exactly one instruction and halts at the next boundary.
  - If halted from reset (cause=00), skip stays 0, so a step halts at the first boundary reached.
- break_cause holds its value until the next halt; it is not cleared on leaving HALTED.
- bp_addr may change while halted; the new value applies from the next cycle. bp_enable=0 disables compare in all states.
- Reset (any state, mid-step included), next cycle:
  - state=RUN, or HALTED if START_HALTED=1.
  - skip=0, cause=00, hit_count=0.
  - cpu_run = 1 when START_HALTED=0, 0 when START_HALTED=1.
  - halted = START_HALTED.

Test Plan:
- bp_addr=0x0150, bp_enable=1; CPU fetches 0x0100…0x0150 → cpu_run drops combinationally in the 0x0150 instr_start cycle; halted=1 next cycle; cause=01; hit_count=1.
- Continue press while parked at 0x0150 → cpu_run=1 from the cycle after the press; no re-halt at 0x0150; halts again on the next fetch of 0x0150 (loop); hit_count=2.
- Step press parked at 0x0150 with next instruction at 0x0152 → exactly one instruction runs; halts with cpu_addr=0x0152, cause=11, hit_count unchanged.
- RUN with bp_enable=0, halt press mid-instruction → cpu_run stays 1 until the next instr_start, then 0; cause=10.
- Step and continue pressed in the same cycle while HALTED → STEP taken. Button held across reset → no action. START_HALTED=1: first step halts at the first boundary with cause=11.
- hit_count with CNT_W=8 after 300 breakpoint halts → 0xFF. Reset asserted while in STEP → next cycle RUN, cause=00, hit_count=0.
